// File: rtl/pulse_seq_arbiter.sv
// rtl/pulse_seq_arbiter.sv - round-robin arbiter sharing one ARM/MID/DONE pulse sequencer
module pulse_seq_arbiter #(
  parameter int N          = 4,
  parameter int MID_CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] pending,
  output logic [N-1:0] grant,
  output logic [N-1:0] done,
  output logic         busy,
  output logic         out,
  output logic [3:0]   phase
);
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    ARM  = 4'b0010,
    MID  = 4'b0100,
    DONE = 4'b1000
  } state_t;

  state_t        state, state_n;
  logic [RW-1:0] rr, rr_n;
  logic [7:0]    cnt, cnt_n;
  logic [N-1:0]  grant_n, clear, pending_n;
  logic [N-1:0]  win_oh;
  logic [RW-1:0] win_idx, win_nxt, cand;
  logic          win_vld;
  int            idx;

  // Winner search starts at rr and wraps; only registered pending bits take part,
  // so a req arriving on the same edge is never granted in that edge.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = 1'b0;
    idx     = 0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      idx  = (int'(rr) + k) % N;
      cand = RW'(idx);
      if (!win_vld && pending[cand]) begin
        win_vld       = 1'b1;
        win_idx       = cand;
        win_oh[cand]  = 1'b1;
      end
    end
    win_nxt = (win_idx == RW'(N - 1)) ? '0 : win_idx + RW'(1);
  end

  always_comb begin
    state_n = state;
    grant_n = grant;
    rr_n    = rr;
    cnt_n   = cnt;
    clear   = '0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_n = ARM;
          grant_n = win_oh;
          clear   = win_oh;
          rr_n    = win_nxt;
        end
      end
      ARM: begin
        state_n = MID;
        cnt_n   = 8'(MID_CYCLES - 1);
      end
      MID: begin
        if (cnt == 8'd0) state_n = DONE;
        else             cnt_n   = cnt - 8'd1;
      end
      DONE: begin
        if (win_vld) begin
          state_n = ARM;
          grant_n = win_oh;
          clear   = win_oh;
          rr_n    = win_nxt;
        end else begin
          state_n = IDLE;
          grant_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
    // A request landing on its own clearing edge wins and stays pending.
    pending_n = req | (pending & ~clear);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rr      <= '0;
      cnt     <= '0;
      grant   <= '0;
      pending <= '0;
    end else begin
      state   <= state_n;
      rr      <= rr_n;
      cnt     <= cnt_n;
      grant   <= grant_n;
      pending <= pending_n;
    end
  end

  assign out   = (state == DONE);
  assign busy  = (state == ARM) || (state == MID) || (state == DONE);
  assign done  = out ? grant : '0;
  assign phase = state;

endmodule
